fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage and IF/ID pipeline register of the 5-stage MIPS core. Holds PCF and fetches from
//  instruction memory over a req/ready handshake. Delivers InstrD/PCPlus4D to decode.
//  Consumes StallF/StallD from the hazard unit and PCSrcD/PCBranchD from decode.
//  Inserts bubbles on memory wait and on taken branch, and buffers one instruction while decode stalls.
// PARAMETERS
//  RESET_PC  32'h0040_0000  PCF value after reset (MIPS .text base)
//  NOP       32'h0000_0000  bubble encoding driven on InstrD (sll $0,$0,0)
// PORTS
//  clk         in   1   core clock, all state on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  StallF      in   1   hazard: do not launch a new fetch
//  StallD      in   1   hazard: hold IF/ID register
//  PCSrcD      in   1   decode: branch/jump taken this cycle
//  PCBranchD   in   32  decode: redirect target
//  imem_req    out  1   fetch request valid
//  imem_addr   out  32  fetch address (= PCF, word aligned)
//  imem_ready  in   1   memory: imem_rdata valid, request complete this cycle
//  imem_rdata  in   32  instruction word
//  InstrD      out  32  IF/ID instruction
//  PCPlus4D    out  32  IF/ID PC+4 of InstrD
//  ValidD      out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async, rst_n=0): PCF=RESET_PC, state=BOOT, InstrD=NOP, PCPlus4D=0, ValidD=0, imem_req=0 immediately.
//    An in-flight request is abandoned; memory tolerates this.
//  States: BOOT -> FETCH after 1 cycle, imem_req=0 in BOOT. FETCH: request. HOLD: instr buffered.
//    DRAIN: wrong-path request in flight.
//  imem_req = (FETCH && (!StallF || inflight)) || DRAIN. inflight = req high last cycle and ready low.
//    Once raised, req and addr are held stable until ready; StallF never drops an in-flight req.
//  done = imem_req && imem_ready. Zero-wait memory gives 1 instr/cycle, PCF->InstrD latency 1 cycle.
//  FETCH:
//    StallD=1: IF/ID holds. On done, buf<=rdata and go to HOLD. PCF holds.
//    StallD=0, PCSrcD=1: IF/ID<=bubble. On done, PCF<=PCBranchD and stay in FETCH.
//      Without done, tgt<=PCBranchD and go to DRAIN.
//    StallD=0, PCSrcD=0: on done, IF/ID<={rdata,PCF+4,1} and PCF<=PCF+4.
//      Otherwise IF/ID<=bubble (NOP,PCPlus4D held,0).
//  HOLD (req=0):
//    StallD=1: hold.
//    PCSrcD=1: discard buf, IF/ID<=bubble, PCF<=PCBranchD, go to FETCH.
//    Otherwise: IF/ID<={buf,PCF+4,1}, PCF<=PCF+4, go to FETCH.
//  DRAIN: addr is the old PCF. IF/ID<=bubble unless StallD. On done, rdata is discarded, PCF<=tgt, go to FETCH.
//    PCSrcD is ignored (decode holds a bubble).
//  PCSrcD is ignored whenever StallD=1: the stalled branch's operands are not yet valid.
//  PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
//  imem_addr[1:0] is always 2'b00. PCBranchD[1:0] is forced to 0.
// STRUCTURE
//  mips_pkg: fetch_state_t {BOOT,FETCH,HOLD,DRAIN}, RESET_PC, NOP localparams.
//  One sub-module, if_id_reg: {InstrD,PCPlus4D,ValidD} with load/hold/bubble controls and async reset.
//  The FSM, PCF, buf, tgt and the request logic live in fetch_stage.
// TESTING
//  1. Reset release with ready tied 1: BOOT cycle has req=0. Addrs 0x00400000, 04, 08 follow on consecutive
//     cycles. InstrD follows 1 cycle later, ValidD=1.
//  2. ready low 3 cycles at 0x00400008: addr stable, ValidD=0 for 3 cycles, then InstrD=word@08, PCPlus4D=0x0040000C.
//  3. StallD=StallF=1 for 2 cycles while done: IF/ID frozen, req=0 in HOLD. Release gives buffered word, no refetch.
//  4. PCSrcD=1, PCBranchD=0x00400100 with done: ValidD=0 next cycle, next addr 0x00400100.
//     Same with ready low: DRAIN, old word discarded, then 0x00400100.
//  5. StallF=1 raised while req in flight, ready low: req stays high until ready. No new req while StallF=1.
//  6. rst_n low mid-DRAIN: req=0 and ValidD=0 same cycle. After release, restart at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
// Fetch FSM encoding plus reset PC and bubble encoding.
package mips_pkg;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      HOLD,
      DRAIN
   } fetch_state_t;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   function automatic logic [31:0] word_align(
      input logic [31:0] a
   );
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit.
// Load has the data path; bubble clears instr/valid but keeps PC+4.
module if_id_reg #(
   parameter logic [31:0] NOP = mips_pkg::NOP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        bubble_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pcplus4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pcplus4_o,
   output logic        valid_o
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      unique case (1'b1)
         load_i: begin
            instr_d = instr_i;
            pc4_d   = pcplus4_i;
            valid_d = 1'b1;
         end
         bubble_i: begin
            instr_d = NOP;
            valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= NOP;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr_o   = instr_q;
   assign pcplus4_o = pc4_q;
   assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, imem req/ready handshake, branch redirect,
// one-entry decode-stall buffer, feeding the IF/ID register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
   parameter logic [31:0] NOP      = mips_pkg::NOP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        PCSrcD,
   input  logic [31:0] PCBranchD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   import mips_pkg::fetch_state_t;
   import mips_pkg::BOOT;
   import mips_pkg::FETCH;
   import mips_pkg::HOLD;
   import mips_pkg::DRAIN;
   import mips_pkg::word_align;

   fetch_state_t state_q, state_d;
   logic [31:0]  pcf_q, pcf_d;
   logic [31:0]  buf_q, buf_d;
   logic [31:0]  tgt_q, tgt_d;
   logic         inflight_q, inflight_d;

   logic        req;
   logic        done;
   logic [31:0] br;
   logic [31:0] pcf4;
   logic        ld;
   logic        bub;
   logic [31:0] ld_instr;

   assign br   = word_align(PCBranchD);
   assign pcf4 = pcf_q + 32'd4;

   // An issued request must stay up until ready, even under StallF.
   always_comb begin
      req = 1'b0;
      unique case (state_q)
         FETCH:   req = !StallF || inflight_q;
         DRAIN:   req = 1'b1;
         default: req = 1'b0;
      endcase
   end

   assign done       = req && imem_ready;
   assign inflight_d = req && !imem_ready;
   assign imem_req   = req;
   assign imem_addr  = word_align(pcf_q);

   always_comb begin
      state_d  = state_q;
      pcf_d    = pcf_q;
      buf_d    = buf_q;
      tgt_d    = tgt_q;
      ld       = 1'b0;
      bub      = 1'b0;
      ld_instr = imem_rdata;
      unique case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            if (StallD) begin
               if (done) begin
                  buf_d   = imem_rdata;
                  state_d = HOLD;
               end
            end else if (PCSrcD) begin
               bub = 1'b1;
               if (done) begin
                  pcf_d = br;
               end else begin
                  tgt_d   = br;
                  state_d = DRAIN;
               end
            end else if (done) begin
               ld    = 1'b1;
               pcf_d = pcf4;
            end else begin
               bub = 1'b1;
            end
         end
         HOLD: begin
            if (!StallD) begin
               state_d = FETCH;
               if (PCSrcD) begin
                  bub   = 1'b1;
                  pcf_d = br;
               end else begin
                  ld       = 1'b1;
                  ld_instr = buf_q;
                  pcf_d    = pcf4;
               end
            end
         end
         DRAIN: begin
            bub = !StallD;
            if (done) begin
               pcf_d   = tgt_q;
               state_d = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pcf_q      <= RESET_PC;
         buf_q      <= NOP;
         tgt_q      <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcf_q      <= pcf_d;
         buf_q      <= buf_d;
         tgt_q      <= tgt_d;
         inflight_q <= inflight_d;
      end
   end

   if_id_reg #(
      .NOP(NOP)
   ) u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (ld),
      .bubble_i (bub),
      .instr_i  (ld_instr),
      .pcplus4_i(pcf4),
      .instr_o  (InstrD),
      .pcplus4_o(PCPlus4D),
      .valid_o  (ValidD)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a zero-latency
// instruction memory whose word is a fixed function of address.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        StallF;
   logic        StallD;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   int n_cmp;
   int n_err;

   fetch_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .StallF    (StallF),
      .StallD    (StallD),
      .PCSrcD    (PCSrcD),
      .PCBranchD (PCBranchD),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ready(imem_ready),
      .imem_rdata(imem_rdata),
      .InstrD    (InstrD),
      .PCPlus4D  (PCPlus4D),
      .ValidD    (ValidD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] wd(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   assign imem_rdata = wd(imem_addr);

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic drv(
      input logic        r,
      input logic        sf,
      input logic        sd,
      input logic        ps,
      input logic [31:0] b
   );
      imem_ready = r;
      StallF     = sf;
      StallD     = sd;
      PCSrcD     = ps;
      PCBranchD  = b;
      @(negedge clk);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(
      input string       tag,
      input logic [31:0] i,
      input logic [31:0] p,
      input logic        v
   );
      chk({tag, ".instr"}, InstrD, i);
      chk({tag, ".pc4"}, PCPlus4D, p);
      chk({tag, ".valid"}, {31'd0, ValidD}, {31'd0, v});
   endtask

   task automatic chk_req(
      input string       tag,
      input logic        r,
      input logic [31:0] a
   );
      chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
      if (r) chk({tag, ".addr"}, imem_addr, a);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      drv(1, 0, 0, 0, 0);
      chk_req("rst", 0, 0);
      chk_ifid("rst", 32'h0, 32'h0, 0);
      rst_n = 1'b1;
      #1;
      chk_req("boot", 0, 0);
      step();

      // 1: back-to-back fetches
      drv(1, 0, 0, 0, 0);
      chk_req("f0", 1, 32'h0040_0000);
      chk_ifid("f0", 32'h0, 32'h0, 0);
      step();
      drv(1, 0, 0, 0, 0);
      chk_req("f1", 1, 32'h0040_0004);
      chk_ifid("f1", wd(32'h0040_0000), 32'h0040_0004, 1);
      step();

      // 2: three wait states at 0x08
      drv(0, 0, 0, 0, 0);
      chk_req("f2", 1, 32'h0040_0008);
      chk_ifid("f2", wd(32'h0040_0004), 32'h0040_0008, 1);
      step();
      drv(0, 0, 0, 0, 0);
      chk_req("w1", 1, 32'h0040_0008);
      chk_ifid("w1", 32'h0, 32'h0040_0008, 0);
      step();
      drv(0, 0, 0, 0, 0);
      chk_req("w2", 1, 32'h0040_0008);
      chk("w2.valid", {31'd0, ValidD}, 32'd0);
      step();
      drv(1, 0, 0, 0, 0);
      chk_req("w3", 1, 32'h0040_0008);
      chk("w3.valid", {31'd0, ValidD}, 32'd0);
      step();
      drv(1, 0, 0, 0, 0);
      chk_req("c0", 1, 32'h0040_000C);
      chk_ifid("c0", wd(32'h0040_0008), 32'h0040_000C, 1);
      step();

      // 3: full stall, then decode-only stall into HOLD
      drv(1, 1, 1, 0, 0);
      chk_req("s1", 0, 0);
      chk_ifid("s1", wd(32'h0040_000C), 32'h0040_0010, 1);
      step();
      drv(1, 1, 1, 0, 0);
      chk_req("s2", 0, 0);
      chk_ifid("s2", wd(32'h0040_000C), 32'h0040_0010, 1);
      step();
      drv(1, 0, 1, 0, 0);
      chk_req("h0", 1, 32'h0040_0010);
      step();
      drv(1, 1, 1, 0, 0);
      chk_req("h1", 0, 0);
      chk_ifid("h1", wd(32'h0040_000C), 32'h0040_0010, 1);
      step();
      drv(1, 0, 0, 0, 0);
      chk_req("h2", 0, 0);
      step();

      // 4a: taken branch with done
      drv(1, 0, 0, 1, 32'h0040_0100);
      chk_req("n", 1, 32'h0040_0014);
      chk_ifid("n", wd(32'h0040_0010), 32'h0040_0014, 1);
      step();
      drv(1, 0, 0, 0, 0);
      chk_req("b1", 1, 32'h0040_0100);
      chk_ifid("b1", 32'h0, 32'h0040_0014, 0);
      step();

      // 4b: taken branch while memory waits -> DRAIN
      drv(0, 0, 0, 1, 32'h0040_0203);
      chk_req("b2", 1, 32'h0040_0104);
      chk_ifid("b2", wd(32'h0040_0100), 32'h0040_0104, 1);
      step();
      drv(0, 0, 0, 1, 32'h0040_0300);
      chk_req("d1", 1, 32'h0040_0104);
      chk("d1.valid", {31'd0, ValidD}, 32'd0);
      step();
      drv(1, 0, 0, 0, 0);
      chk_req("d2", 1, 32'h0040_0104);
      step();
      drv(1, 0, 0, 0, 0);
      chk_req("d3", 1, 32'h0040_0200);
      chk_ifid("d3", 32'h0, 32'h0040_0104, 0);
      step();

      // 5: StallF raised while a request is outstanding
      drv(0, 0, 0, 0, 0);
      chk_req("p0", 1, 32'h0040_0204);
      chk_ifid("p0", wd(32'h0040_0200), 32'h0040_0204, 1);
      step();
      drv(0, 1, 0, 0, 0);
      chk_req("p1", 1, 32'h0040_0204);
      step();
      drv(1, 1, 0, 0, 0);
      chk_req("p2", 1, 32'h0040_0204);
      step();
      drv(1, 1, 0, 0, 0);
      chk_req("p3", 0, 0);
      chk_ifid("p3", wd(32'h0040_0204), 32'h0040_0208, 1);
      step();
      drv(1, 1, 0, 0, 0);
      chk_req("p4", 0, 0);
      chk("p4.valid", {31'd0, ValidD}, 32'd0);
      step();

      // 6: async reset in the middle of DRAIN
      drv(0, 0, 0, 1, 32'h0040_0400);
      chk_req("r0", 1, 32'h0040_0208);
      step();
      drv(0, 0, 0, 0, 0);
      chk_req("r1", 1, 32'h0040_0208);
      rst_n = 1'b0;
      #1;
      chk_req("r2", 0, 0);
      chk_ifid("r2", 32'h0, 32'h0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_req("r3", 0, 0);
      step();
      drv(1, 0, 0, 0, 0);
      chk_req("r4", 1, 32'h0040_0000);
      step();

      // PC wraps past the top of the address space
      drv(1, 0, 0, 1, 32'hFFFF_FFFC);
      step();
      drv(1, 0, 0, 0, 0);
      chk_req("x0", 1, 32'hFFFF_FFFC);
      step();
      drv(1, 0, 0, 0, 0);
      chk_req("x1", 1, 32'h0000_0000);
      chk_ifid("x1", wd(32'hFFFF_FFFC), 32'h0, 1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
